// File: rtl/axis_arb_mux_n.sv
// N-input AXI4-Stream packet arbiter/mux with a 2-entry registered output buffer.
// Define AXIS_ARB_MUX_USER_EN to carry tuser through alongside tdata/tlast.
module axis_arb_mux_n #(
  parameter int    S_COUNT      = 4,
  parameter int    DATA_WIDTH   = 8,
  parameter int    USER_WIDTH   = 1,
  parameter string ARB_TYPE     = "PRIORITY",
  parameter string LSB_PRIORITY = "HIGH"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   input_axis_tdata,
  input  logic [S_COUNT-1:0]              input_axis_tvalid,
  output logic [S_COUNT-1:0]              input_axis_tready,
  input  logic [S_COUNT-1:0]              input_axis_tlast,
`ifdef AXIS_ARB_MUX_USER_EN
  input  logic [S_COUNT*USER_WIDTH-1:0]   input_axis_tuser,
  output logic [USER_WIDTH-1:0]           output_axis_tuser,
`endif
  output logic [DATA_WIDTH-1:0]           output_axis_tdata,
  output logic                            output_axis_tvalid,
  input  logic                            output_axis_tready,
  output logic                            output_axis_tlast,
  output logic [S_COUNT-1:0]              grant,
  output logic                            grant_valid,
  output logic [$clog2(S_COUNT)-1:0]      grant_encoded
);

  localparam int IW = $clog2(S_COUNT);
`ifdef AXIS_ARB_MUX_USER_EN
  localparam int UW = USER_WIDTH;
`else
  localparam int UW = 0 * USER_WIDTH;
`endif
  localparam int EW     = DATA_WIDTH + 1 + UW;
  localparam bit RR     = (ARB_TYPE == "ROUND_ROBIN");
  localparam bit LSB_HI = (LSB_PRIORITY == "HIGH");

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [S_COUNT-1:0] grant_q;
  logic [IW-1:0]      gidx_q, rr_q, win_idx;
  logic               win_found;
  logic [EW-1:0]      head_q, tail_q, in_entry;
  logic [1:0]         cnt_q;
  logic               full, push, pop, in_last;

  // Search order: rotating from rr_q for round-robin, otherwise fixed.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < S_COUNT; k++) begin
      if (RR)          j = (int'(rr_q) + k) % S_COUNT;
      else if (LSB_HI) j = k;
      else             j = S_COUNT - 1 - k;
      if (!win_found && input_axis_tvalid[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  assign push    = input_axis_tvalid[gidx_q] & input_axis_tready[gidx_q];
  assign in_last = input_axis_tlast[gidx_q];
`ifdef AXIS_ARB_MUX_USER_EN
  assign in_entry = {input_axis_tuser[int'(gidx_q)*USER_WIDTH +: USER_WIDTH], in_last,
                     input_axis_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH]};
`else
  assign in_entry = {in_last, input_axis_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (win_found) state_d = ACTIVE;
      ACTIVE: if (push && in_last) state_d = IDLE;
    endcase
  end

  always_comb begin
    input_axis_tready = '0;
    if (state_q == ACTIVE) input_axis_tready[gidx_q] = !full;
  end

  // Grant is released on the accepted tlast beat without waiting for the buffer to drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else if (state_q == IDLE) begin
      if (win_found) begin
        grant_q          <= '0;
        grant_q[win_idx] <= 1'b1;
        gidx_q           <= win_idx;
      end
    end else if (push && in_last) begin
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= (int'(gidx_q) == S_COUNT - 1) ? '0 : gidx_q + 1'b1;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == ACTIVE);
  assign grant_encoded = gidx_q;

  // head_q drives the outputs; tail_q only holds the second beat while downstream stalls.
  assign full = (cnt_q == 2'd2);
  assign pop  = output_axis_tvalid & output_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (cnt_q)
        2'd0: if (push) begin
          head_q <= in_entry;
          cnt_q  <= 2'd1;
        end
        2'd1: if (push && pop) begin
          head_q <= in_entry;
        end else if (push) begin
          tail_q <= in_entry;
          cnt_q  <= 2'd2;
        end else if (pop) begin
          cnt_q  <= 2'd0;
        end
        2'd2: if (pop) begin
          head_q <= tail_q;
          cnt_q  <= 2'd1;
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  assign output_axis_tvalid = (cnt_q != 2'd0);
  assign output_axis_tdata  = head_q[DATA_WIDTH-1:0];
  assign output_axis_tlast  = head_q[DATA_WIDTH];
`ifdef AXIS_ARB_MUX_USER_EN
  assign output_axis_tuser  = head_q[EW-1 -: USER_WIDTH];
`endif

endmodule

// File: tb/tb_axis_arb_mux_n.sv
// Bench for axis_arb_mux_n: a PRIORITY and a ROUND_ROBIN instance checked every cycle
// against a queue-level model, plus directed packet sequences with fixed expected output.
module tb_axis_arb_mux_n;
  localparam int S     = 4;
  localparam int DW    = 8;
  localparam int UW    = 1;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][S*DW-1:0] tdata;
  logic [1:0][S-1:0]    tvalid, tready, tlast, tuser, grant;
  logic [1:0][DW-1:0]   odata;
  logic [1:0]           ovalid, oready, olast, gvalid;
  logic [1:0][1:0]      genc;
`ifdef AXIS_ARB_MUX_USER_EN
  logic [1:0][UW-1:0]   ouser;
`endif

  axis_arb_mux_n #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW),
                   .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("HIGH")) u_pri (
    .clk(clk), .rst(rst),
    .input_axis_tdata(tdata[0]), .input_axis_tvalid(tvalid[0]),
    .input_axis_tready(tready[0]), .input_axis_tlast(tlast[0]),
`ifdef AXIS_ARB_MUX_USER_EN
    .input_axis_tuser(tuser[0]), .output_axis_tuser(ouser[0]),
`endif
    .output_axis_tdata(odata[0]), .output_axis_tvalid(ovalid[0]),
    .output_axis_tready(oready[0]), .output_axis_tlast(olast[0]),
    .grant(grant[0]), .grant_valid(gvalid[0]), .grant_encoded(genc[0])
  );

  axis_arb_mux_n #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW),
                   .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH")) u_rr (
    .clk(clk), .rst(rst),
    .input_axis_tdata(tdata[1]), .input_axis_tvalid(tvalid[1]),
    .input_axis_tready(tready[1]), .input_axis_tlast(tlast[1]),
`ifdef AXIS_ARB_MUX_USER_EN
    .input_axis_tuser(tuser[1]), .output_axis_tuser(ouser[1]),
`endif
    .output_axis_tdata(odata[1]), .output_axis_tvalid(ovalid[1]),
    .output_axis_tready(oready[1]), .output_axis_tlast(olast[1]),
    .grant(grant[1]), .grant_valid(gvalid[1]), .grant_encoded(genc[1])
  );

  // Reference state: owner of the current packet and the queued output beats {user,last,data}.
  bit            m_busy  [2];
  int            m_own   [2];
  int            m_start [2];
  int            mc      [2];
  logic [DW+1:0] mf      [2][2];
  // Per-port beat scripts: head sh, tail st; gate=0 forces tvalid low.
  logic [DW+1:0] sb   [2][S][DEPTH];
  int            sh   [2][S];
  int            st   [2][S];
  bit            gate [2][S];
  logic [DW-1:0] obs0 [$];
  logic [DW-1:0] obs1 [$];
  logic [DW-1:0] exq  [$];
  int n_cmp = 0;
  int n_bad = 0;
  int total [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int arb(input int d, input logic [S-1:0] v, input int start);
    int j;
    for (int k = 0; k < S; k++) begin
      j = (d == 0) ? k : (start + k) % S;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic add(input int d, input int p, input logic [7:0] data, input bit last, input bit user);
    sb[d][p][st[d][p]] = {user, last, data};
    st[d][p]++;
    total[d]++;
  endtask

  task automatic add_pkt(input int d, input int p, input logic [7:0] base, input int len, input bit ulast);
    for (int i = 0; i < len; i++) add(d, p, base + 8'(i), i == len - 1, ulast && (i == len - 1));
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_own[d] = 0; m_start[d] = 0; mc[d] = 0;
    end
  endtask

  task automatic clear_scripts();
    for (int d = 0; d < 2; d++) begin
      total[d] = 0;
      for (int p = 0; p < S; p++) begin
        sh[d][p] = 0; st[d][p] = 0; gate[d][p] = 1'b1;
      end
    end
    obs0.delete(); obs1.delete();
  endtask

  task automatic drive();
    logic [DW+1:0] e;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < S; p++) begin
        if (gate[d][p] && sh[d][p] < st[d][p]) begin
          e = sb[d][p][sh[d][p]];
          tvalid[d][p] = 1'b1;
          tdata[d][p*DW +: DW] = e[DW-1:0];
          tlast[d][p] = e[DW];
          tuser[d][p] = e[DW+1];
        end else begin
          tvalid[d][p] = 1'b0;
          tdata[d][p*DW +: DW] = '0;
          tlast[d][p] = 1'b0;
          tuser[d][p] = 1'b0;
        end
      end
  endtask

  task automatic check_all();
    logic [S-1:0] er, eg;
    for (int d = 0; d < 2; d++) begin
      er = '0; eg = '0;
      if (m_busy[d]) begin
        eg[m_own[d]] = 1'b1;
        if (mc[d] < 2) er[m_own[d]] = 1'b1;
      end
      chk($sformatf("tready%0d", d), tready[d], er);
      chk($sformatf("grant%0d", d), grant[d], eg);
      chk($sformatf("grant_valid%0d", d), gvalid[d], m_busy[d]);
      chk($sformatf("grant_enc%0d", d), genc[d], m_busy[d] ? m_own[d] : 0);
      chk($sformatf("ovalid%0d", d), ovalid[d], mc[d] > 0);
      if (mc[d] > 0) begin
        chk($sformatf("obeat%0d", d), {olast[d], odata[d]}, mf[d][0][DW:0]);
`ifdef AXIS_ARB_MUX_USER_EN
        chk($sformatf("ouser%0d", d), ouser[d], mf[d][0][DW+1]);
`endif
      end
      if (ovalid[d] && oready[d]) begin
        if (d == 0) obs0.push_back(odata[d]);
        else        obs1.push_back(odata[d]);
      end
    end
  endtask

  task automatic model_step();
    bit push, pop;
    logic [DW+1:0] ent;
    int o, w;
    for (int d = 0; d < 2; d++) begin
      o    = m_own[d];
      pop  = (mc[d] > 0) && oready[d];
      push = m_busy[d] && (mc[d] < 2) && tvalid[d][o];
      ent  = {tuser[d][o], tlast[d][o], tdata[d][o*DW +: DW]};
      if (pop) begin mf[d][0] = mf[d][1]; mc[d]--; end
      if (push) begin mf[d][mc[d]] = ent; mc[d]++; sh[d][o]++; end
      if (!m_busy[d]) begin
        w = arb(d, tvalid[d], m_start[d]);
        if (w >= 0) begin m_busy[d] = 1'b1; m_own[d] = w; end
      end else if (push && ent[DW]) begin
        m_busy[d]  = 1'b0;
        m_start[d] = (o + 1) % S;
      end
    end
  endtask

  task automatic pre();
    drive();
    #1;
    check_all();
  endtask

  task automatic post();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc();
    pre();
    post();
  endtask

  task automatic chk_obs(input int d, input string tag);
    int n;
    n = (d == 0) ? obs0.size() : obs1.size();
    chk({tag, "_len"}, n, exq.size());
    for (int i = 0; i < exq.size() && i < n; i++)
      chk($sformatf("%s_%0d", tag, i), (d == 0) ? obs0[i] : obs1[i], exq[i]);
  endtask

  function automatic bit all_done();
    for (int d = 0; d < 2; d++) begin
      if (mc[d] != 0 || m_busy[d]) return 1'b0;
      for (int p = 0; p < S; p++) if (sh[d][p] != st[d][p]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, nb;
    rst = 1'b1; oready = '0;
    tvalid = '0; tdata = '0; tlast = '0; tuser = '0;
    reset_model(); clear_scripts();
    repeat (2) @(negedge clk);
    pre();
    chk("rst_odata", odata[0], 0);
    chk("rst_olast", olast[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Priority pair on instance 0, round-robin sweep on instance 1.
    add_pkt(0, 1, 8'h10, 3, 1'b0);
    add_pkt(0, 3, 8'h30, 3, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < S; p++) add(1, p, 8'(p), 1'b1, 1'b0);
    oready = 2'b11;
    repeat (30) cyc();
    exq = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
    chk_obs(0, "prio_seq");
    exq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03};
    chk_obs(1, "rr_seq");

    // Downstream stall fills the buffer.
    clear_scripts();
    add_pkt(0, 2, 8'h20, 4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      oready[0] = !(k >= 3 && k <= 5);
      pre();
      if (k == 4) chk("stall_tready2", tready[0][2], 1'b0);
      post();
    end
    exq = '{8'h20, 8'h21, 8'h22, 8'h23};
    chk_obs(0, "stall_seq");

    // Mid-packet tvalid drop keeps the grant.
    clear_scripts();
    oready = 2'b11;
    add(0, 0, 8'h01, 1'b0, 1'b0);
    add(0, 0, 8'h02, 1'b1, 1'b0);
    add(0, 1, 8'h40, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) begin
      gate[0][0] = !(k >= 2 && k < 7);
      pre();
      if (k == 4) begin
        chk("hold_grant", grant[0], 4'b0001);
        chk("hold_p1_tready", tready[0][1], 1'b0);
      end
      post();
    end
    exq = '{8'h01, 8'h02, 8'h40};
    chk_obs(0, "hold_seq");

    // Reset with two beats buffered.
    clear_scripts();
    oready = 2'b00;
    add_pkt(0, 3, 8'h50, 5, 1'b0);
    repeat (3) cyc();
    pre();
    chk("pre_rst_ovalid", ovalid[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ovalid", ovalid[0], 1'b0);
    chk("rst_mid_grant", grant[0], 4'b0000);
    chk("rst_mid_gvalid", gvalid[0], 1'b0);
    reset_model(); clear_scripts();
    @(negedge clk);
    rst = 1'b0;
    oready = 2'b11;
    add_pkt(0, 2, 8'h60, 2, 1'b1);
    repeat (8) cyc();
    exq = '{8'h60, 8'h61};
    chk_obs(0, "post_rst_seq");

    // Randomized traffic on both instances.
    clear_scripts();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < S; p++) begin
        nb = 0;
        while (nb < 30) begin
          len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++)
            add(d, p, 8'(p * 64 + nb + i), i == len - 1, 1'($urandom));
          nb += len;
        end
      end
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < S; p++) gate[d][p] = ($urandom % 4) != 0;
      oready = 2'($urandom);
      cyc();
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < S; p++) gate[d][p] = 1'b1;
    oready = 2'b11;
    for (int k = 0; k < 600 && !all_done(); k++) cyc();
    chk("rand_drained", all_done(), 1'b1);
    chk("rand_beats0", obs0.size(), total[0]);
    chk("rand_beats1", obs1.size(), total[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axis_arb_mux_n.md
Name: axis_arb_mux_n

Overview:
Parametrised N-input AXI4-Stream arbitrated multiplexer; successor to the fixed 4-port arbitrated mux. Arbitrates per packet: the grant is held from first beat to the accepted tlast beat. Selectable priority or round-robin arbitration. Registered output (2-entry skid buffer) so output_axis_tready never combinationally reaches the input tready signals.

Parameters:
S_COUNT, 4, number of input ports (2..16)
DATA_WIDTH, 8, tdata width per port
USER_WIDTH, 1, tuser width per port (used only with the optional feature)
ARB_TYPE, "PRIORITY", "PRIORITY" or "ROUND_ROBIN"
LSB_PRIORITY, "HIGH", "HIGH": port 0 has highest fixed priority; "LOW": port S_COUNT-1 has highest fixed priority

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
input_axis_tdata  in  S_COUNT*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
input_axis_tvalid  in  S_COUNT  per-port valid
input_axis_tready  out  S_COUNT  per-port ready
input_axis_tlast  in  S_COUNT  per-port last
output_axis_tdata  out  DATA_WIDTH  muxed data
output_axis_tvalid  out  1  output valid
output_axis_tready  in  1  downstream ready
output_axis_tlast  out  1  muxed last
grant  out  S_COUNT  one-hot current grant (status)
grant_valid  out  1  packet in progress
grant_encoded  out  $clog2(S_COUNT)  binary index of grant; 0 when grant_valid=0

Behaviour:
- Reset (async assert, sync release): grant=0, grant_valid=0, grant_encoded=0, output_axis_tvalid=0, output_axis_tdata=0, output_axis_tlast=0, input_axis_tready=0, skid buffer empty, round-robin pointer=0.
- FSM IDLE/ACTIVE.
- IDLE: input_axis_tready=0. If any tvalid is high, the winner is registered; next cycle the FSM is ACTIVE with grant one-hot and grant_valid=1. Arbitration latency 1 cycle.
- PRIORITY: the highest-priority valid port wins, per LSB_PRIORITY.
- ROUND_ROBIN: the first valid port strictly after the last granted index, searching upward with wrap; ties broken by that search order only. After reset the search starts at index 0.
- ACTIVE: input_axis_tready[g] = skid buffer not full; all other tready bits are 0. A transfer on port g pushes {tdata,tlast} into the skid buffer.
- Transfer with tlast=1 on port g: next cycle grant=0, grant_valid=0, FSM returns to IDLE, RR pointer updated to g. This gives a one-cycle bubble between packets, so the minimum packet gap on the input is 1 cycle.
- Skid buffer: output_axis_tvalid=1 while it holds data. Pop on output_axis_tvalid&output_axis_tready. Simultaneous push and pop with 1 entry keeps 1 entry. Full at 2 entries: tready drops.
- Input-to-output latency is 1 cycle. Sustained throughput is 1 beat/cycle with output_axis_tready held high.
- Release of grant does not wait for the skid buffer to drain; the next packet may enter behind buffered beats. Beat order on the output is strictly preserved.
- A port's tvalid dropping mid-packet does not release the grant; the mux waits indefinitely for tlast.
- Non-granted ports are never back-pressured combinationally by other ports' data.
- Reset mid-packet: buffered beats are discarded, the grant is cleared, and the output goes invalid immediately (async).
- grant is always $onehot0. A grant never rises for port i unless input_axis_tvalid[i] was high the previous cycle.

Optional Feature:
AXIS_ARB_MUX_USER_EN
- Defined: adds input_axis_tuser [S_COUNT*USER_WIDTH] and output_axis_tuser [USER_WIDTH]. tuser is carried through the skid buffer alongside tdata and tlast; output_axis_tuser resets to 0.
- Undefined: the tuser ports do not exist and USER_WIDTH is ignored. No tuser storage is built.

Test Plan:
- Reset, then S_COUNT=4, PRIORITY/HIGH, ports 1 and 3 valid together, each with a 3-beat packet (0x10..0x12, 0x30..0x32), output_axis_tready=1 -> output sequence 0x10,0x11,0x12, one bubble, then 0x30,0x31,0x32. grant=0010 then 1000; grant_encoded=1 then 3.
- ROUND_ROBIN, all 4 ports continuously offering 1-beat packets (data = port index) -> output 0,1,2,3,0,1,... Each grant lasts exactly 1 beat.
- Port 2 packet of 4 beats with output_axis_tready low for 3 cycles after beat 1 -> skid buffer fills, input_axis_tready[2]=0 while full. No beat is lost or duplicated; output order is 0x20..0x23.
- Port 0 sends beat 0x01 with tlast=0, then its tvalid drops for 5 cycles while port 1 is valid -> grant stays 0001 and port 1 tready stays 0. Port 0 then sends 0x02 with tlast=1, after which port 1 is granted.
- Assert rst mid-packet with 2 beats buffered -> output_axis_tvalid=0 and grant=0 in the same cycle. After release, the first transfer is the next arbitrated packet.
- With AXIS_ARB_MUX_USER_EN defined, port 3 sends tuser=1 on its last beat -> output_axis_tuser=1 is coincident with output_axis_tlast=1.
